// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the 6502 fetch path:
// fetch states, instruction lengths, reset vector and special opcodes.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_OP  = 2'd0,
        S_B1  = 2'd1,
        S_B2  = 2'd2,
        S_OUT = 2'd3
    } fetch_state_t;

    localparam logic [1:0] LEN1 = 2'd1;
    localparam logic [1:0] LEN2 = 2'd2;
    localparam logic [1:0] LEN3 = 2'd3;

    localparam logic [15:0] RESET_PC_DEF = 16'h0200;

    localparam logic [7:0] BRK = 8'h00;
    localparam logic [7:0] JSR = 8'h20;
    localparam logic [7:0] RTI = 8'h40;
    localparam logic [7:0] RTS = 8'h60;

endpackage

// File: rtl/fetch_unit_len_decode.sv
// 6502 instruction length from the opcode byte (aaabbbcc).
// Shared with the decoder and the disassembly monitor.
module inst_len_decode
    import fetch_unit_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    always_comb begin
        len = LEN2;
        unique case (1'b1)
            (opcode == BRK) || (opcode == RTI) || (opcode == RTS): len = LEN1;
            opcode[3:0] == 4'h8:       len = LEN1;
            opcode[3:0] == 4'hA:       len = LEN1;
            opcode == JSR:             len = LEN3;
            opcode[4:0] == 5'b10000:   len = LEN2;
            default: begin
                // cc is irrelevant once the special rows are excluded
                case (opcode[4:2])
                    3'b011, 3'b110, 3'b111: len = LEN3;
                    default:                len = LEN2;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch and assembly stage: streams program bytes, assembles
// opcode plus operands and hands one instruction to the decoder.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [7:0]  inst_opcode,
    output logic [7:0]  inst_op1,
    output logic [7:0]  inst_op2,
    output logic [1:0]  inst_len,
    output logic [15:0] inst_pc
);

    fetch_state_t state, state_nx;

    logic [15:0] fetch_pc;
    logic [15:0] rd_addr;
    logic        rd_pending;
    logic        skid_valid;
    logic [7:0]  skid_byte;
    logic [15:0] skid_addr;

    logic        arrive;
    logic        have_byte;
    logic        consume;
    logic        handshake;
    logic [7:0]  byte_in;
    logic [15:0] byte_addr;
    logic [1:0]  dec_len;

    assign mem_rd_en  = (state != S_OUT) && !skid_valid && !redirect_valid;
    assign mem_addr   = fetch_pc;
    assign inst_valid = (state == S_OUT);
    assign handshake  = inst_valid && inst_ready;

    // The skid byte is always older than anything in flight
    assign arrive    = rd_pending && !redirect_valid;
    assign have_byte = skid_valid || arrive;
    assign byte_in   = skid_valid ? skid_byte : mem_rdata;
    assign byte_addr = skid_valid ? skid_addr : rd_addr;
    assign consume   = have_byte && (state != S_OUT) && !redirect_valid;

    inst_len_decode u_len (
        .opcode (byte_in),
        .len    (dec_len)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_OP;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (redirect_valid) begin
            state_nx = S_OP;
        end else begin
            unique case (state)
                S_OP:  if (have_byte) state_nx = (dec_len == LEN1) ? S_OUT : S_B1;
                S_B1:  if (have_byte) state_nx = (inst_len == LEN2) ? S_OUT : S_B2;
                S_B2:  if (have_byte) state_nx = S_OUT;
                S_OUT: if (handshake) state_nx = S_OP;
                default: state_nx = S_OP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            rd_addr     <= RESET_PC;
            rd_pending  <= 1'b0;
            skid_valid  <= 1'b0;
            skid_byte   <= 8'h00;
            skid_addr   <= RESET_PC;
            inst_opcode <= 8'h00;
            inst_op1    <= 8'h00;
            inst_op2    <= 8'h00;
            inst_len    <= LEN1;
            inst_pc     <= RESET_PC;
        end else begin
            rd_pending <= mem_rd_en;
            if (mem_rd_en) begin
                rd_addr  <= fetch_pc;
                fetch_pc <= fetch_pc + 16'd1;
            end
            if (redirect_valid) begin
                fetch_pc   <= redirect_pc;
                skid_valid <= 1'b0;
            end else if ((state == S_OUT) && arrive) begin
                skid_valid <= 1'b1;
                skid_byte  <= mem_rdata;
                skid_addr  <= rd_addr;
            end else if (consume && skid_valid) begin
                skid_valid <= 1'b0;
            end
            if (consume) begin
                unique case (state)
                    S_OP: begin
                        inst_opcode <= byte_in;
                        inst_op1    <= 8'h00;
                        inst_op2    <= 8'h00;
                        inst_len    <= dec_len;
                        inst_pc     <= byte_addr;
                    end
                    S_B1:    inst_op1 <= byte_in;
                    S_B2:    inst_op2 <= byte_in;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed programs, expected
// instructions queued by stimulus and checked by a handshake monitor.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [7:0]  inst_opcode;
    logic [7:0]  inst_op1;
    logic [7:0]  inst_op2;
    logic [1:0]  inst_len;
    logic [15:0] inst_pc;

    logic [7:0]  dec_op = 8'h00;
    logic [1:0]  dec_len;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  len;
        logic [15:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0200)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_opcode    (inst_opcode),
        .inst_op1       (inst_op1),
        .inst_op2       (inst_op2),
        .inst_len       (inst_len),
        .inst_pc        (inst_pc)
    );

    inst_len_decode u_dec (
        .opcode (dec_op),
        .len    (dec_len)
    );

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_inst: got op %h pc %h want none",
                         inst_opcode, inst_pc);
            end else begin
                e = exp_q.pop_front();
                check("inst_opcode", {24'h0, inst_opcode}, {24'h0, e.op});
                check("inst_op1", {24'h0, inst_op1}, {24'h0, e.a});
                check("inst_op2", {24'h0, inst_op2}, {24'h0, e.b});
                check("inst_len", {30'h0, inst_len}, {30'h0, e.len});
                check("inst_pc", {16'h0, inst_pc}, {16'h0, e.pc});
            end
        end
        if (rst_n && dut.rd_pending && dut.skid_valid && !redirect_valid) begin
            n_bad++;
            $display("FAIL skid_overflow: got arrival with full skid want none");
        end
    end

    function automatic logic [1:0] ref_len(logic [7:0] b);
        logic [3:0] lo;
        lo = b[3:0];
        if (b == 8'h00 || b == 8'h40 || b == 8'h60) return 2'd1;
        if (b == 8'h20) return 2'd3;
        if (lo == 4'h8 || lo == 4'hA) return 2'd1;
        if (lo < 4'h8) return 2'd2;
        if (lo >= 4'hC) return 2'd3;
        return b[4] ? 2'd3 : 2'd2;
    endfunction

    task automatic push(logic [7:0] op, logic [7:0] a, logic [7:0] b,
                        logic [1:0] len, logic [15:0] pc);
        exp_t e;
        e = '{op: op, a: a, b: b, len: len, pc: pc};
        exp_q.push_back(e);
    endtask

    task automatic enter_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        #1 check("rst_valid", {31'h0, inst_valid}, 32'h0);
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        exp_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic leave_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic latency(string name, int want);
        int lat;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (inst_valid) begin
                lat = i;
                break;
            end
        end
        check(name, lat, want);
    endtask

    task automatic wait_issue(string name, logic [15:0] addr);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_rd_en && mem_addr == addr) break;
        end
        n_cmp++;
        if (k >= 40) begin
            n_bad++;
            $display("FAIL %s: got no issue want addr %h", name, addr);
        end
    endtask

    task automatic drain(string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        inst_ready = 1'b0;
        n_cmp++;
        if (k >= 200) begin
            n_bad++;
            $display("FAIL %s: got %0d pending want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    logic [7:0] sp_op [8];
    logic [1:0] sp_len [8];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // two-byte immediate, reset values and latency
        enter_reset();
        mem[16'h0200] = 8'hA9;
        mem[16'h0201] = 8'h05;
        check("rst_opcode", {24'h0, inst_opcode}, 32'h0);
        check("rst_op1", {24'h0, inst_op1}, 32'h0);
        check("rst_op2", {24'h0, inst_op2}, 32'h0);
        check("rst_len", {30'h0, inst_len}, 32'h1);
        check("rst_pc", {16'h0, inst_pc}, 32'h0200);
        push(8'hA9, 8'h05, 8'h00, 2'd2, 16'h0200);
        inst_ready = 1'b1;
        leave_reset();
        #1 check("first_rd_en", {31'h0, mem_rd_en}, 32'h1);
        check("first_addr", {16'h0, mem_addr}, 32'h0200);
        latency("lat_len2", 3);
        drain("drain_a9");

        // mixed stream, ready high
        enter_reset();
        mem[16'h0200] = 8'hEA;
        mem[16'h0201] = 8'hAD;
        mem[16'h0202] = 8'h34;
        mem[16'h0203] = 8'h12;
        mem[16'h0204] = 8'h10;
        mem[16'h0205] = 8'hFE;
        push(8'hEA, 8'h00, 8'h00, 2'd1, 16'h0200);
        push(8'hAD, 8'h34, 8'h12, 2'd3, 16'h0201);
        push(8'h10, 8'hFE, 8'h00, 2'd2, 16'h0204);
        inst_ready = 1'b1;
        leave_reset();
        latency("lat_len1", 2);
        drain("drain_stream");

        // same stream, decoder stalls on the first instruction
        enter_reset();
        mem[16'h0200] = 8'hEA;
        mem[16'h0201] = 8'hAD;
        mem[16'h0202] = 8'h34;
        mem[16'h0203] = 8'h12;
        mem[16'h0204] = 8'h10;
        mem[16'h0205] = 8'hFE;
        push(8'hEA, 8'h00, 8'h00, 2'd1, 16'h0200);
        push(8'hAD, 8'h34, 8'h12, 2'd3, 16'h0201);
        push(8'h10, 8'hFE, 8'h00, 2'd2, 16'h0204);
        leave_reset();
        latency("stall_lat", 2);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'h0, inst_valid}, 32'h1);
            check("stall_rd_en", {31'h0, mem_rd_en}, 32'h0);
            check("stall_opcode", {24'h0, inst_opcode}, 32'hEA);
            check("stall_pc", {16'h0, inst_pc}, 32'h0200);
            @(negedge clk);
        end
        @(posedge clk);
        #1 inst_ready = 1'b1;
        drain("drain_stall");

        // redirect while collecting op1 of AD at 0201
        enter_reset();
        mem[16'h0200] = 8'hEA;
        mem[16'h0201] = 8'hAD;
        mem[16'h0202] = 8'h34;
        mem[16'h0203] = 8'h12;
        mem[16'h8000] = 8'h18;
        push(8'hEA, 8'h00, 8'h00, 2'd1, 16'h0200);
        push(8'h18, 8'h00, 8'h00, 2'd1, 16'h8000);
        inst_ready = 1'b1;
        leave_reset();
        wait_issue("wait_b1", 16'h0202);
        #1 redirect_pc = 16'h8000;
        redirect_valid = 1'b1;
        #1 check("redir_no_issue", {31'h0, mem_rd_en}, 32'h0);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        check("redir_addr", {16'h0, mem_addr}, 32'h8000);
        drain("drain_redir");

        // redirect to the top of memory, operands wrap to 0000
        enter_reset();
        mem[16'hFFFE] = 8'h20;
        mem[16'hFFFF] = 8'h00;
        mem[16'h0000] = 8'h03;
        mem[16'h0001] = 8'h18;
        push(8'h20, 8'h00, 8'h03, 2'd3, 16'hFFFE);
        push(8'h18, 8'h00, 8'h00, 2'd1, 16'h0001);
        inst_ready = 1'b1;
        leave_reset();
        redirect_pc = 16'hFFFE;
        redirect_valid = 1'b1;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        drain("drain_wrap");

        // length decoder sweep and spot checks
        for (int i = 0; i < 256; i++) begin
            dec_op = i[7:0];
            #1 check("len_sweep", {30'h0, dec_len}, {30'h0, ref_len(i[7:0])});
        end
        sp_op  = '{8'h00, 8'h20, 8'h6C, 8'h0A, 8'hA2, 8'h91, 8'hB9, 8'hF0};
        sp_len = '{2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd2, 2'd3, 2'd2};
        for (int i = 0; i < 8; i++) begin
            dec_op = sp_op[i];
            #1 check("len_spot", {30'h0, dec_len}, {30'h0, sp_len[i]});
        end

        // reset pulse while waiting for op2
        enter_reset();
        mem[16'h0200] = 8'hAD;
        mem[16'h0201] = 8'h34;
        mem[16'h0202] = 8'h12;
        inst_ready = 1'b1;
        leave_reset();
        wait_issue("wait_b2", 16'h0203);
        #1 rst_n = 1'b0;
        #1 check("midrst_valid", {31'h0, inst_valid}, 32'h0);
        check("midrst_opcode", {24'h0, inst_opcode}, 32'h0);
        check("midrst_op1", {24'h0, inst_op1}, 32'h0);
        check("midrst_addr", {16'h0, mem_addr}, 32'h0200);
        push(8'hAD, 8'h34, 8'h12, 2'd3, 16'h0200);
        repeat (2) @(posedge clk);
        leave_reset();
        #1 check("refetch_addr", {16'h0, mem_addr}, 32'h0200);
        drain("drain_refetch");

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
